// File: rtl/seq_multiplier_32_pkg.sv
// -----------------------------------------------------------------------------
// seq_multiplier_32_pkg
// Shared definitions for the sequential 32-bit multiplier: operand width,
// iteration count, counter width and the control FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package seq_multiplier_32_pkg;

  // Operand width. Only 32 is supported; the product is 2*WIDTH bits.
  localparam int WIDTH      = 32;
  // One shift-add step per multiplier bit.
  localparam int MULT_STEPS = 32;
  localparam int CNT_W      = $clog2(MULT_STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage : seq_multiplier_32_pkg

// File: rtl/seq_multiplier_32_if.sv
// -----------------------------------------------------------------------------
// seq_multiplier_32_if
// Request/response bundle between the EX stage (master) and the multiplier
// (slave).
//   start      EX -> mul  request, accepted only while the multiplier is idle
//   is_signed  EX -> mul  1 = mult (two's complement), 0 = multu
//   op_a       EX -> mul  multiplicand (rs)
//   op_b       EX -> mul  multiplier (rt)
//   busy       mul -> EX  operation in progress, EX stalls
//   done       mul -> EX  one-cycle pulse, hi/lo valid
//   hi, lo     mul -> EX  product[63:32], product[31:0]
// -----------------------------------------------------------------------------
interface seq_multiplier_32_if;
  import seq_multiplier_32_pkg::*;

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, op_a, op_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b,
    output busy, done, hi, lo
  );

endinterface : seq_multiplier_32_if

// File: rtl/cla_adder_32.sv
// -----------------------------------------------------------------------------
// cla_adder_32
// 32-bit carry-lookahead adder built from eight 4-bit lookahead groups.
//   a_i, b_i  in   32-bit operands
//   c_i       in   carry in
//   sum_o     out  32-bit sum
//   c_o       out  carry out of bit 31
// -----------------------------------------------------------------------------
module cla_adder_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_i,
  output logic [31:0] sum_o,
  output logic        c_o
);

  logic [31:0] gen;
  logic [31:0] prop;
  logic [32:0] carry;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // Inside each group every carry is expanded from the group carry-in, so
  // only the group boundaries form a chain.
  always_comb begin
    int b;
    // NOTE: every variable gets a value before any branch or loop so the
    // block stays purely combinational and no latch is inferred.
    carry    = '0;
    b        = 0;
    carry[0] = c_i;
    for (int grp = 0; grp < 8; grp++) begin
      b = grp * 4;
      carry[b+1] = gen[b] | (prop[b] & carry[b]);
      carry[b+2] = gen[b+1] | (prop[b+1] & gen[b])
                 | (prop[b+1] & prop[b] & carry[b]);
      carry[b+3] = gen[b+2] | (prop[b+2] & gen[b+1])
                 | (prop[b+2] & prop[b+1] & gen[b])
                 | (prop[b+2] & prop[b+1] & prop[b] & carry[b]);
      carry[b+4] = gen[b+3] | (prop[b+3] & gen[b+2])
                 | (prop[b+3] & prop[b+2] & gen[b+1])
                 | (prop[b+3] & prop[b+2] & prop[b+1] & gen[b])
                 | (prop[b+3] & prop[b+2] & prop[b+1] & prop[b] & carry[b]);
    end
  end

  assign sum_o = prop ^ carry[31:0];
  assign c_o   = carry[32];

endmodule : cla_adder_32

// File: rtl/twos_negate_64.sv
// -----------------------------------------------------------------------------
// twos_negate_64
// Combinational 64-bit two's complement negation (~x + 1).
//   x_i  in   value to negate
//   y_o  out  -x_i modulo 2^64
// -----------------------------------------------------------------------------
module twos_negate_64 (
  input  logic [63:0] x_i,
  output logic [63:0] y_o
);

  assign y_o = ~x_i + 64'd1;

endmodule : twos_negate_64

// File: rtl/seq_multiplier_32.sv
// -----------------------------------------------------------------------------
// seq_multiplier_32
// Multi-cycle shift-add multiplier for MIPS mult/multu. Signed operands are
// multiplied as magnitudes and the 64-bit product is negated at the end when
// the operand signs differ. One multiplier bit is retired per cycle through
// the shared 32-bit carry-lookahead adder; done follows start by 34 cycles.
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset (discards any operation)
//   mul    slave modport of seq_multiplier_32_if (start/is_signed/op_a/op_b
//          in; busy/done/hi/lo out)
// -----------------------------------------------------------------------------
module seq_multiplier_32
  import seq_multiplier_32_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  seq_multiplier_32_if.slave  mul
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MULT_STEPS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // ---------------------------------------------------------------------------
  // Operand magnitudes. The negators are 64-bit; only the low half is used
  // for the zero-extended operands. |0x80000000| stays 0x80000000, which is
  // the correct unsigned magnitude.
  // ---------------------------------------------------------------------------
  logic [63:0]      neg_a, neg_b, neg_p;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             unused_neg_hi;

  twos_negate_64 u_neg_a (.x_i({32'b0, mul.op_a}), .y_o(neg_a));
  twos_negate_64 u_neg_b (.x_i({32'b0, mul.op_b}), .y_o(neg_b));
  twos_negate_64 u_neg_p (.x_i(prod_q),            .y_o(neg_p));

  assign mag_a = (mul.is_signed && mul.op_a[31]) ? neg_a[31:0] : mul.op_a;
  assign mag_b = (mul.is_signed && mul.op_b[31]) ? neg_b[31:0] : mul.op_b;
  assign unused_neg_hi = ^{neg_a[63:32], neg_b[63:32]};

  // ---------------------------------------------------------------------------
  // Upper-half accumulation: sum = P[63:32] + mcand, c_in = 0. The carry-out
  // becomes the new P[63] after the right shift, so no product bit is lost.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH:0]   upper_next;
  logic [2*WIDTH-1:0] prod_step;

  cla_adder_32 u_add (
    .a_i   (prod_q[63:32]),
    .b_i   (mcand_q),
    .c_i   (1'b0),
    .sum_o (add_sum),
    .c_o   (add_cout)
  );

  assign upper_next = prod_q[0] ? {add_cout, add_sum} : {1'b0, prod_q[63:32]};
  assign prod_step  = {upper_next, prod_q[31:1]};

  // ---------------------------------------------------------------------------
  // Control FSM and datapath next state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      IDLE: begin
        if (mul.start) begin
          neg_d   = mul.is_signed & (mul.op_a[31] ^ mul.op_b[31]);
          mcand_d = mag_a;
          prod_d  = {{WIDTH{1'b0}}, mag_b};
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = FIX;
        end
      end
      FIX: begin
        prod_d  = neg_q ? neg_p : prod_q;
        hi_d    = prod_d[63:32];
        lo_d    = prod_d[31:0];
        state_d = DONE;
      end
      DONE: begin
        // A start seen here is dropped; the requester reissues in IDLE.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign mul.busy = (state_q == CALC) || (state_q == FIX);
  assign mul.done = (state_q == DONE);
  assign mul.hi   = hi_q;
  assign mul.lo   = lo_q;

endmodule : seq_multiplier_32

// File: tb/tb_seq_multiplier_32.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier_32
// Directed bench for seq_multiplier_32. Expected products are queued when an
// operation is issued and popped when done is observed. Inputs change on the
// falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seq_multiplier_32;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic reset;

  seq_multiplier_32_if bus ();

  seq_multiplier_32 dut (
    .clk   (clk),
    .reset (reset),
    .mul   (bus.slave)
  );

  always #5 clk = ~clk;

  res_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (s) return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Called on a falling edge; start is seen by exactly one rising edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.op_a      = a;
    bus.op_b      = b;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  // Entered on the first falling edge after the start edge. Optionally pulses
  // start at CALC cycle pulse_at and in the DONE cycle.
  task automatic wait_done(input string tag, input int pulse_at, input bit start_in_done);
    int   cycles   = 1;
    int   busy_cnt = 0;
    res_t exp;
    while (!bus.done && cycles < 100) begin
      if (bus.busy) busy_cnt++;
      if (cycles == pulse_at) begin
        bus.start = 1'b1;
        bus.op_a  = 32'd9;
      end
      @(negedge clk);
      bus.start = 1'b0;
      cycles++;
    end
    check({tag, " done seen"}, 64'(bus.done), 64'd1);
    check({tag, " latency"},   64'(cycles),   64'd34);
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, " busy at done"}, 64'(bus.busy), 64'd0);
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard entry"}, 64'd0, 64'd1);
    end else begin
      exp = sb_q.pop_front();
      check({tag, " product"}, {bus.hi, bus.lo}, exp);
    end
    if (start_in_done) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic run(input string tag, input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] exp,
                     input int pulse_at, input bit start_in_done);
    @(negedge clk);
    sb_q.push_back(exp);
    issue(s, a, b);
    wait_done(tag, pulse_at, start_in_done);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;

    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    reset         = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
    check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b0;

    // Largest unsigned operands; full-latency and busy-width checks.
    run("multu max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        64'hFFFF_FFFE_0000_0001, 0, 1'b0);

    // Back-to-back: start in the first IDLE cycle after DONE.
    @(negedge clk);
    sb_q.push_back(64'h0000_0001_0000_0000);
    issue(1'b0, 32'h0001_0000, 32'h0001_0000);
    check("b2b busy", 64'(bus.busy), 64'd1);
    check("b2b old hi/lo held", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    wait_done("multu b2b", 0, 1'b0);

    run("mult -3*7",  1'b1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 0, 1'b0);
    run("multu -3*7", 1'b0, 32'hFFFF_FFFD, 32'd7, 64'h0000_0006_FFFF_FFEB, 0, 1'b0);
    run("mult min*min", 1'b1, 32'h8000_0000, 32'h8000_0000,
        64'h4000_0000_0000_0000, 0, 1'b0);
    run("mult min*1", 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 0, 1'b0);
    run("multu 0*0", 1'b0, 32'd0, 32'd0, 64'd0, 0, 1'b0);

    // Starts while busy and in DONE are ignored.
    run("multu 5*6 ignored starts", 1'b0, 32'd5, 32'd6, 64'd30, 10, 1'b1);
    check("after done state idle", {62'd0, bus.busy, bus.done}, 64'd0);
    repeat (3) @(negedge clk);
    check("no restart busy", 64'(bus.busy), 64'd0);
    check("hi/lo hold 30", {bus.hi, bus.lo}, 64'd30);

    // Reset in CALC cycle 15 discards the operation.
    @(negedge clk);
    issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (14) @(negedge clk);
    check("pre-reset busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
    check("mid reset hi/lo", {bus.hi, bus.lo}, 64'd0);
    repeat (3) @(negedge clk);
    check("post reset idle", 64'(bus.busy), 64'd0);
    run("multu 2*3", 1'b0, 32'd2, 32'd3, 64'd6, 0, 1'b0);

    // A few random operands against the reference model.
    for (int i = 0; i < 4; i++) begin
      ra = $urandom();
      rb = $urandom();
      rs = 1'(i);
      run($sformatf("random %0d", i), rs, ra, rb, model(rs, ra, rb), 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_seq_multiplier_32
